down_counter_tc: RTL and testbench

DOWN_COUNTER_TC -- requirements
Module: down_counter_tc

---
 rtl/down_counter_tc_pkg.sv | 9 +
 rtl/down_counter_tc.sv | 69 ++++++
 tb/tb_down_counter_tc.sv | 134 +++++++++++++
 3 files changed

// File: rtl/down_counter_tc_pkg.sv
// Shared types and defaults for the terminal-count down counter.
package down_counter_tc_pkg;
  localparam int WIDTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/down_counter_tc.sv
// Loadable down counter with one-shot or auto-reload modes and a registered terminal-count pulse.
module down_counter_tc
  import down_counter_tc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             lower,
  output logic             tc,
  output logic             busy
);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      shadow_d = load_val;
      state_d  = (load_val != ZERO) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (count_q == ONE) begin
        tc_d = 1'b1;
        // reload only matters here; in auto-reload mode 0 is never shown
        if (reload) begin
          count_d = shadow_q;
        end else begin
          count_d = ZERO;
          state_d = IDLE;
        end
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign lower = ~count_q[WIDTH-1];
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
endmodule

// File: tb/tb_down_counter_tc.sv
// Directed bench for down_counter_tc at WIDTH=4 with hand-computed expectations.
module tb_down_counter_tc;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         reload;
  logic [W-1:0] count;
  logic         lower;
  logic         tc;
  logic         busy;

  int n_chk;
  int n_pass;

  down_counter_tc #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .reload  (reload),
    .count   (count),
    .lower   (lower),
    .tc      (tc),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input int c, input bit t, input bit b);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    chk({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; reload = 1'b0;
    #12;
    st("rst", 0, 0, 0);
    chk("rst.lower", 32'(lower), 1);
    rst_n = 1'b1;
    en = 1'b1;
    step(); step();
    st("idle_after_rst", 0, 0, 0);

    // one-shot from 3
    load = 1'b1; load_val = 4'd3; reload = 1'b0;
    step(); st("os_load", 3, 0, 1);
    load = 1'b0;
    step(); st("os_2", 2, 0, 1);
    step(); st("os_1", 1, 0, 1);
    step(); st("os_0", 0, 1, 0);
    step(); st("os_after", 0, 0, 0);

    // auto-reload from 2
    load = 1'b1; load_val = 4'd2; reload = 1'b1;
    step(); st("ar_load", 2, 0, 1);
    load = 1'b0;
    step(); st("ar_1a", 1, 0, 1);
    step(); st("ar_2a", 2, 1, 1);
    step(); st("ar_1b", 1, 0, 1);
    step(); st("ar_2b", 2, 1, 1);
    // dropping reload away from the terminal edge changes nothing until then
    reload = 1'b0;
    step(); st("ar_1c", 1, 0, 1);
    step(); st("ar_end", 0, 1, 0);

    // lower flag across full range
    load = 1'b1; load_val = 4'd15;
    step(); st("lw_load", 15, 0, 1);
    chk("lw_15.lower", 32'(lower), 0);
    load = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      step();
      chk($sformatf("lw_%0d.count", i), 32'(count), 32'(i));
      chk($sformatf("lw_%0d.lower", i), 32'(lower), (i < 8) ? 32'd1 : 32'd0);
    end
    chk("lw_end.tc", 32'(tc), 1);

    // en low holds in RUN
    load = 1'b1; load_val = 4'd4; en = 1'b0;
    step(); st("hold_load", 4, 0, 1);
    load = 1'b0;
    step(); step(); st("hold", 4, 0, 1);

    // load beats terminal decrement
    load = 1'b1; load_val = 4'd3; en = 1'b1;
    step(); load = 1'b0;
    step(); step(); st("pri_1", 1, 0, 1);
    load = 1'b1; load_val = 4'd9;
    step(); st("pri_9", 9, 0, 1);
    load = 1'b0;
    step(); st("pri_8", 8, 0, 1);

    // load zero stays idle
    load = 1'b1; load_val = 4'd0;
    step(); st("z_load", 0, 0, 0);
    load = 1'b0;
    step(); step(); st("z_en", 0, 0, 0);

    // async reset mid-run
    load = 1'b1; load_val = 4'd7;
    step(); load = 1'b0;
    step(); step(); st("ar5", 5, 0, 1);
    #2 rst_n = 1'b0;
    #1 st("async", 0, 0, 0);
    chk("async.lower", 32'(lower), 1);
    step(); st("rst_held", 0, 0, 0);
    rst_n = 1'b1;
    step(); st("rel_1", 0, 0, 0);
    step(); st("rel_2", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
